// File: rtl/o_vector_writeback_pkg.sv
// Shared types for the output writeback path: the normalised row, the beat record
// and the beat-count helper.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 8
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 16
`endif

package o_vector_writeback_pkg;
    localparam int VEC_LEN_DEF    = `MAX_EMBEDDING_DIM;
    localparam int DATA_WIDTH_DEF = `INTEGER_WIDTH;
    localparam int LANES_DEF      = 4;
    localparam int ADDR_WIDTH_DEF = 16;

    typedef logic [VEC_LEN_DEF-1:0][DATA_WIDTH_DEF-1:0] O_VECTOR_T;

    typedef struct packed {
        logic [LANES_DEF-1:0][DATA_WIDTH_DEF-1:0] data;
        logic [ADDR_WIDTH_DEF-1:0]                addr;
        logic [LANES_DEF-1:0]                     lane_en;
        logic                                     last;
    } OUT_BEAT_T;

    function automatic int num_beats(input int vec_len, input int lanes);
        return (vec_len + lanes - 1) / lanes;
    endfunction
endpackage

// File: rtl/o_vector_writeback_slicer.sv
// Combinational beat slicer: picks LANES elements of the buffered row for the
// current beat; lanes past the end of the row read as zero with lane_en low.
module wb_beat_slicer #(
    parameter int VEC_LEN    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int BW         = 1
) (
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] row,
    input  logic [BW-1:0]                      beat,
    output logic [LANES-1:0][DATA_WIDTH-1:0]   data,
    output logic [LANES-1:0]                   lane_en
);
    localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    always_comb begin
        int idx;
        data    = '0;
        lane_en = '0;
        idx     = 0;
        for (int l = 0; l < LANES; l++) begin
            idx = int'(beat) * LANES + l;
            if (idx < VEC_LEN) begin
                data[l]    = row[IW'(idx)];
                lane_en[l] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/o_vector_writeback.sv
// Output writeback: buffers one row, streams it as LANES-wide addressed beats and
// counts finished rows; a new row may load on the cycle the last beat leaves.
module o_vector_writeback
    import o_vector_writeback_pkg::*;
#(
    parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
    parameter int DATA_WIDTH = `INTEGER_WIDTH,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_ROWS   = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               vld_in,
    output logic                               rdy_out,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] vec_in,
    input  logic [$clog2(NUM_ROWS)-1:0]        row_idx_in,
    input  logic [ADDR_WIDTH-1:0]              base_addr_in,
    output logic                               vld_out,
    input  logic                               rdy_in,
    output logic [LANES*DATA_WIDTH-1:0]        beat_data_out,
    output logic [ADDR_WIDTH-1:0]              beat_addr_out,
    output logic [LANES-1:0]                   lane_en_out,
    output logic                               last_out,
    output logic [$clog2(NUM_ROWS+1)-1:0]      rows_done_out,
    output logic                               done_out
);
    localparam int NB = num_beats(VEC_LEN, LANES);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(NUM_ROWS + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                             state, state_nxt;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] row_buf;
    logic [BW-1:0]                      beat;
    logic [ADDR_WIDTH-1:0]              addr;
    logic [CW-1:0]                      rows_done;
    logic                               done;
    logic                               last, fire, accept;
    logic [LANES-1:0][DATA_WIDTH-1:0]   slice_data;
    logic [LANES-1:0]                   slice_en;

    assign last    = (state == SEND) && (beat == BW'(NB - 1));
    assign fire    = (state == SEND) && rdy_in;
    // Overlap path: rdy_in passes combinationally to rdy_out on the last beat.
    assign rdy_out = (state == IDLE) || (last && rdy_in);
    assign accept  = vld_in && rdy_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)            state_nxt = SEND;
        else if (fire && last) state_nxt = IDLE;
    end

    // Row address is folded at accept time; later beats step by LANES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_buf   <= '0;
            beat      <= '0;
            addr      <= '0;
            rows_done <= '0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                row_buf <= vec_in;
                beat    <= '0;
                addr    <= base_addr_in + ADDR_WIDTH'(row_idx_in) * ADDR_WIDTH'(VEC_LEN);
            end else if (fire && !last) begin
                beat <= beat + 1'b1;
                addr <= addr + ADDR_WIDTH'(LANES);
            end
            if (fire && last && rows_done != CW'(NUM_ROWS))
                rows_done <= rows_done + 1'b1;
            if (fire && last && rows_done == CW'(NUM_ROWS - 1))
                done <= 1'b1;
        end
    end

    wb_beat_slicer #(
        .VEC_LEN   (VEC_LEN),
        .DATA_WIDTH(DATA_WIDTH),
        .LANES     (LANES),
        .BW        (BW)
    ) u_slicer (
        .row    (row_buf),
        .beat   (beat),
        .data   (slice_data),
        .lane_en(slice_en)
    );

    assign vld_out       = (state == SEND);
    assign beat_data_out = vld_out ? slice_data : '0;
    assign lane_en_out   = vld_out ? slice_en : '0;
    assign beat_addr_out = vld_out ? addr : '0;
    assign last_out      = last;
    assign rows_done_out = rows_done;
    assign done_out      = done;
endmodule

// File: tb/tb_o_vector_writeback.sv
// Randomised bench for o_vector_writeback (6-element rows, 4 lanes, 3-row tile)
// against a queue-of-expected-beats model.
module tb_o_vector_writeback;
    localparam int VL = 6, LN = 4, DW = 8, AW = 16, NR = 3;
    localparam int NB = (VL + LN - 1) / LN;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      vld_in = 1'b0, rdy_in = 1'b0;
    logic                      rdy_out, vld_out, last_out, done_out;
    logic [VL-1:0][DW-1:0]     vec_in = '0;
    logic [$clog2(NR)-1:0]     row_idx_in = '0;
    logic [AW-1:0]             base_addr_in = '0;
    logic [LN*DW-1:0]          beat_data_out;
    logic [AW-1:0]             beat_addr_out;
    logic [LN-1:0]             lane_en_out;
    logic [$clog2(NR+1)-1:0]   rows_done_out;

    typedef struct {
        logic [LN*DW-1:0] data;
        logic [AW-1:0]    addr;
        logic [LN-1:0]    en;
        logic             last;
    } beat_t;

    beat_t q[$];
    int checks = 0, errors = 0, model_rows = 0;

    always #5 clk = ~clk;

    o_vector_writeback #(
        .VEC_LEN(VL), .DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .NUM_ROWS(NR)
    ) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .vec_in(vec_in),
        .row_idx_in(row_idx_in), .base_addr_in(base_addr_in), .vld_out(vld_out),
        .rdy_in(rdy_in), .beat_data_out(beat_data_out), .beat_addr_out(beat_addr_out),
        .lane_en_out(lane_en_out), .last_out(last_out), .rows_done_out(rows_done_out),
        .done_out(done_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of a row, straight from the element/address rules.
    task automatic push_row();
        for (int b = 0; b < NB; b++) begin
            beat_t e;
            e.addr = AW'(int'(base_addr_in) + int'(row_idx_in) * VL + b * LN);
            e.data = '0;
            e.en   = '0;
            for (int l = 0; l < LN; l++) begin
                if (b * LN + l < VL) begin
                    e.data[l*DW +: DW] = vec_in[b * LN + l];
                    e.en[l]            = 1'b1;
                end
            end
            e.last = (b == NB - 1);
            q.push_back(e);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_vld"},  vld_out, 0);
        chk({tag, "_last"}, last_out, 0);
        chk({tag, "_en"},   lane_en_out, 0);
        chk({tag, "_data"}, beat_data_out, 0);
        chk({tag, "_addr"}, beat_addr_out, 0);
    endtask

    task automatic step(input bit v, input bit r, input bit rnd);
        bit exp_rdy, fire, acc;
        @(negedge clk);
        vld_in = v;
        rdy_in = r;
        if (v && rnd) begin
            for (int i = 0; i < VL; i++) vec_in[i] = DW'($urandom);
            row_idx_in   = 2'($urandom_range(0, NR - 1));
            base_addr_in = AW'($urandom);
        end
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && r);
        chk("vld_out", vld_out, q.size() != 0);
        chk("rdy_out", rdy_out, exp_rdy);
        chk("rows_done", rows_done_out, model_rows);
        chk("done", done_out, model_rows == NR);
        if (q.size() != 0) begin
            chk("beat_data", beat_data_out, q[0].data);
            chk("beat_addr", beat_addr_out, q[0].addr);
            chk("lane_en", lane_en_out, q[0].en);
            chk("last", last_out, q[0].last);
        end else begin
            chk("idle_en", lane_en_out, 0);
            chk("idle_last", last_out, 0);
        end
        fire = (q.size() != 0) && r;
        acc  = v && exp_rdy;
        if (fire) begin
            if (q[0].last && model_rows < NR) model_rows++;
            void'(q.pop_front());
        end
        if (acc) push_row();
    endtask

    initial begin
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_zero_outputs("reset");
        chk("reset_rdy", rdy_out, 1);
        chk("reset_rows", rows_done_out, 0);
        chk("reset_done", done_out, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed row: base 0x100, row 2, elements 1..6.
        base_addr_in = 16'h0100;
        row_idx_in   = 2'd2;
        for (int i = 0; i < VL; i++) vec_in[i] = DW'(i + 1);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("first_row_rows", rows_done_out, 1);

        // Backpressure mid-row.
        step(1, 1, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);

        // Back-to-back rows, first one wrapping the address space.
        base_addr_in = 16'hFFFE;
        row_idx_in   = 2'd2;
        step(1, 1, 0);
        repeat (7) step(1, 1, 1);

        repeat (300) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 1);

        // Drain, then reset during the second beat of a row.
        for (int k = 0; k < 10 && q.size() != 0; k++) step(0, 1, 0);
        chk("drained", q.size(), 0);
        step(1, 1, 1);
        step(0, 1, 0);
        @(negedge clk);
        vld_in = 1'b0;
        rst    = 1'b0;
        #1 chk_zero_outputs("midrow_reset");
        chk("midrow_rows", rows_done_out, 0);
        chk("midrow_done", done_out, 0);
        q.delete();
        model_rows = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(0, 1, 0);

        repeat (150) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/o_vector_writeback.md
Name: o_vector_writeback

Overview:
Output writeback stage placed directly downstream of vector_division. Accepts one normalised output row (O_VECTOR_T) per handshake, together with its query-row index. Serialises the row into LANES-wide beats with a memory address, lane-valid mask and last flag for the output SRAM/DMA port. Counts completed rows and raises a sticky done flag when the tile is fully written.

Parameters:
VEC_LEN, `MAX_EMBEDDING_DIM, elements per output row
DATA_WIDTH, `INTEGER_WIDTH, bits per element
LANES, 4, elements per output beat; 1..VEC_LEN
ADDR_WIDTH, 16, element-address width
NUM_ROWS, 64, rows per tile; done asserts after this many rows

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
vld_in  in  1  upstream row valid
rdy_out  out  1  ready to accept a row
vec_in  in  O_VECTOR_T  VEC_LEN x DATA_WIDTH row from vector_division
row_idx_in  in  $clog2(NUM_ROWS)  query-row index of vec_in
base_addr_in  in  ADDR_WIDTH  tile base element address; sampled on each row accept
vld_out  out  1  beat valid
rdy_in  in  1  downstream accepts beat
beat_data_out  out  LANES*DATA_WIDTH  beat payload; lane 0 in LSBs
beat_addr_out  out  ADDR_WIDTH  element address of lane 0
lane_en_out  out  LANES  per-lane valid mask
last_out  out  1  final beat of the row
rows_done_out  out  $clog2(NUM_ROWS+1)  rows fully written
done_out  out  1  sticky: rows_done_out == NUM_ROWS

Behaviour:
- Reset (rst low, async): FSM=IDLE, beat counter 0, rows_done_out 0, done_out 0, vld_out 0, last_out 0, lane_en_out 0, beat_data_out 0, beat_addr_out 0. Reset mid-row drops the row silently; no partial beats after release.
- NUM_BEATS = ceil(VEC_LEN/LANES). Padded lanes on the final beat drive 0 and have lane_en=0. All other beats have lane_en all-ones.
- FSM IDLE: rdy_out=1, vld_out=0. On vld_in&&rdy_out, register vec_in, row_idx and base_addr into the row buffer, beat=0, go SEND. First beat is valid the next cycle (1-cycle accept-to-beat latency).
- FSM SEND: vld_out=1. Outputs are driven from registers:
  - beat_data = elements [beat*LANES +: LANES]
  - beat_addr = base + row_idx*VEC_LEN + beat*LANES, truncated modulo 2^ADDR_WIDTH (wrap permitted, no flag)
  - last_out = (beat == NUM_BEATS-1)
  - Outputs hold stable while vld_out && !rdy_in.
  - On vld_out&&rdy_in&&!last_out: beat++.
- Last-beat overlap: rdy_out = IDLE || (SEND && last_out && rdy_in). This is a combinational path from rdy_in. If a row is accepted in the same cycle the last beat fires, load the new row, beat=0, stay SEND, giving back-to-back rows with no bubble. If the last beat fires and no row is accepted, go IDLE.
- rows_done_out increments on each last-beat handshake and saturates at NUM_ROWS. done_out sets in the cycle rows_done_out reaches NUM_ROWS and clears only on reset. Rows arriving after done are still written; the counter stays saturated.
- vld_out must never drop without a handshake. vec_in and row_idx_in are don't-care when vld_in=0.
- row_idx_in >= NUM_ROWS: address is computed arithmetically with no check (verification must not generate this).

Decomposition:
- Shared package: O_VECTOR_T (already shared with vector_division), an OUT_BEAT_T struct {data, addr, lane_en, last}, and the NUM_BEATS localparam helper.
- One natural sub-module: wb_beat_slicer. It is combinational and produces data and lane_en from the row buffer and the beat index. The FSM, counters and address generation stay in o_vector_writeback.

Test Plan:
- VEC_LEN=8, LANES=4, base=0x100, row_idx=2, elements 1..8, rdy_in=1 -> beat0 addr 0x110 data {4,3,2,1} lane_en 1111 last 0; beat1 addr 0x114 data {8,7,6,5} last 1; rows_done 1.
- VEC_LEN=6, LANES=4, row_idx=0, base=0 -> beat1 addr 4, lane_en 0011, upper lanes 0, last 1.
- Back-to-back: vld_in held high with rows A,B, rdy_in=1 -> 4 consecutive beats with no vld_out gap; rdy_out pulses only in the last-beat cycle.
- Backpressure: rdy_in toggles 0,0,1 mid-row -> data, addr and last held stable while stalled; no beat skipped or duplicated; rdy_out=0 throughout SEND until the last beat fires.
- NUM_ROWS=3, send 4 rows -> done_out rises on the 3rd last-beat handshake; rows_done stays 3 after the 4th; the 4th row is still written.
- Assert rst low during beat1 of a 2-beat row -> all outputs 0 immediately; after release rdy_out=1, rows_done=0, no residual beat.
